// File: rtl/zap_wb_walk_fill_arbiter_if.sv
// Signal bundle between the walker/cache-engine masters, the arbiter and the memory-side slave.
// The master modport is the arbiter's view; the slave modport is the surrounding environment's view.
interface zap_wb_walk_fill_arbiter_if;
    logic        i_tlb_wb_cyc_nxt;
    logic        i_tlb_wb_stb_nxt;
    logic [31:0] i_tlb_wb_adr_nxt;
    logic        i_tlb_wb_wen_nxt;
    logic [3:0]  i_tlb_wb_sel_nxt;
    logic [31:0] i_tlb_wb_dat_nxt;

    logic        i_cache_wb_cyc_nxt;
    logic        i_cache_wb_stb_nxt;
    logic [31:0] i_cache_wb_adr_nxt;
    logic        i_cache_wb_wen_nxt;
    logic [3:0]  i_cache_wb_sel_nxt;
    logic [31:0] i_cache_wb_dat_nxt;
    logic [2:0]  i_cache_wb_cti_nxt;

    logic        o_tlb_wb_ack;
    logic        o_tlb_wb_err;
    logic        o_cache_wb_ack;
    logic        o_cache_wb_err;
    logic [31:0] o_wb_rdat;

    logic        o_wb_cyc;
    logic        o_wb_stb;
    logic [31:0] o_wb_adr;
    logic        o_wb_wen;
    logic [3:0]  o_wb_sel;
    logic [31:0] o_wb_dat;
    logic [2:0]  o_wb_cti;

    logic        i_wb_ack;
    logic        i_wb_err;
    logic [31:0] i_wb_dat;

    modport master (
        input  i_tlb_wb_cyc_nxt, i_tlb_wb_stb_nxt, i_tlb_wb_adr_nxt,
               i_tlb_wb_wen_nxt, i_tlb_wb_sel_nxt, i_tlb_wb_dat_nxt,
        input  i_cache_wb_cyc_nxt, i_cache_wb_stb_nxt, i_cache_wb_adr_nxt,
               i_cache_wb_wen_nxt, i_cache_wb_sel_nxt, i_cache_wb_dat_nxt,
               i_cache_wb_cti_nxt,
        output o_tlb_wb_ack, o_tlb_wb_err, o_cache_wb_ack, o_cache_wb_err, o_wb_rdat,
        output o_wb_cyc, o_wb_stb, o_wb_adr, o_wb_wen, o_wb_sel, o_wb_dat, o_wb_cti,
        input  i_wb_ack, i_wb_err, i_wb_dat
    );

    modport slave (
        output i_tlb_wb_cyc_nxt, i_tlb_wb_stb_nxt, i_tlb_wb_adr_nxt,
               i_tlb_wb_wen_nxt, i_tlb_wb_sel_nxt, i_tlb_wb_dat_nxt,
        output i_cache_wb_cyc_nxt, i_cache_wb_stb_nxt, i_cache_wb_adr_nxt,
               i_cache_wb_wen_nxt, i_cache_wb_sel_nxt, i_cache_wb_dat_nxt,
               i_cache_wb_cti_nxt,
        input  o_tlb_wb_ack, o_tlb_wb_err, o_cache_wb_ack, o_cache_wb_err, o_wb_rdat,
        input  o_wb_cyc, o_wb_stb, o_wb_adr, o_wb_wen, o_wb_sel, o_wb_dat, o_wb_cti,
        output i_wb_ack, i_wb_err, i_wb_dat
    );
endinterface

// File: rtl/zap_wb_walk_fill_arbiter.sv
// Registered round-robin arbiter merging the TLB walker and cache fill/write-back engine
// onto one Wishbone master port; grants stay locked until the owner drops cyc.
module zap_wb_walk_fill_arbiter (
    input  logic                              i_clk,
    input  logic                              i_reset,
    zap_wb_walk_fill_arbiter_if.master        bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TLB   = 2'd1,
        ST_CACHE = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic        last_q,  last_d;   // 0: TLB won the last grant, 1: cache did

    logic        cyc_q, cyc_d;
    logic        stb_q, stb_d;
    logic [31:0] adr_q, adr_d;
    logic        wen_q, wen_d;
    logic [3:0]  sel_q, sel_d;
    logic [31:0] dat_q, dat_d;
    logic [2:0]  cti_q, cti_d;

    always_comb begin
        // NOTE: every combinationally assigned signal gets a default first so no path infers a latch.
        state_d = state_q;
        last_d  = last_q;
        cyc_d   = 1'b0;
        stb_d   = 1'b0;
        adr_d   = 32'd0;
        wen_d   = 1'b0;
        sel_d   = 4'd0;
        dat_d   = 32'd0;
        cti_d   = 3'b000;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.i_tlb_wb_cyc_nxt && bus.i_cache_wb_cyc_nxt) begin
                    state_d = last_q ? ST_TLB : ST_CACHE;
                end else if (bus.i_tlb_wb_cyc_nxt) begin
                    state_d = ST_TLB;
                end else if (bus.i_cache_wb_cyc_nxt) begin
                    state_d = ST_CACHE;
                end
            end
            ST_TLB: begin
                if (!bus.i_tlb_wb_cyc_nxt) state_d = ST_IDLE;
            end
            ST_CACHE: begin
                if (!bus.i_cache_wb_cyc_nxt) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_q == ST_IDLE && state_d == ST_TLB)   last_d = 1'b0;
        if (state_q == ST_IDLE && state_d == ST_CACHE) last_d = 1'b1;

        // Bus registers follow the owner chosen for the next cycle, not the current one.
        unique case (state_d)
            ST_TLB: begin
                cyc_d = bus.i_tlb_wb_cyc_nxt;
                stb_d = bus.i_tlb_wb_stb_nxt;
                adr_d = bus.i_tlb_wb_adr_nxt;
                wen_d = bus.i_tlb_wb_wen_nxt;
                sel_d = bus.i_tlb_wb_sel_nxt;
                dat_d = bus.i_tlb_wb_dat_nxt;
                cti_d = 3'b111;
            end
            ST_CACHE: begin
                cyc_d = bus.i_cache_wb_cyc_nxt;
                stb_d = bus.i_cache_wb_stb_nxt;
                adr_d = bus.i_cache_wb_adr_nxt;
                wen_d = bus.i_cache_wb_wen_nxt;
                sel_d = bus.i_cache_wb_sel_nxt;
                dat_d = bus.i_cache_wb_dat_nxt;
                cti_d = bus.i_cache_wb_cti_nxt;
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            last_q  <= 1'b1;
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            adr_q   <= 32'd0;
            wen_q   <= 1'b0;
            sel_q   <= 4'd0;
            dat_q   <= 32'd0;
            cti_q   <= 3'b000;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cyc_q   <= cyc_d;
            stb_q   <= stb_d;
            adr_q   <= adr_d;
            wen_q   <= wen_d;
            sel_q   <= sel_d;
            dat_q   <= dat_d;
            cti_q   <= cti_d;
        end
    end

    assign bus.o_wb_cyc = cyc_q;
    assign bus.o_wb_stb = stb_q;
    assign bus.o_wb_adr = adr_q;
    assign bus.o_wb_wen = wen_q;
    assign bus.o_wb_sel = sel_q;
    assign bus.o_wb_dat = dat_q;
    assign bus.o_wb_cti = cti_q;

    // Responses steer by the current owner with no added latency; anything arriving in IDLE is dropped.
    assign bus.o_tlb_wb_ack   = bus.i_wb_ack & (state_q == ST_TLB);
    assign bus.o_tlb_wb_err   = bus.i_wb_err & (state_q == ST_TLB);
    assign bus.o_cache_wb_ack = bus.i_wb_ack & (state_q == ST_CACHE);
    assign bus.o_cache_wb_err = bus.i_wb_err & (state_q == ST_CACHE);
    assign bus.o_wb_rdat      = bus.i_wb_dat;

endmodule

// File: tb/tb_zap_wb_walk_fill_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic against an owner/last reference model.
module tb_zap_wb_walk_fill_arbiter;

    typedef struct packed {
        logic        rst;
        logic        t_cyc, t_stb, t_wen;
        logic [31:0] t_adr, t_dat;
        logic [3:0]  t_sel;
        logic        c_cyc, c_stb, c_wen;
        logic [31:0] c_adr, c_dat;
        logic [3:0]  c_sel;
        logic [2:0]  c_cti;
        logic        ack, err;
        logic [31:0] rdat;
    } stim_t;

    localparam int OWN_IDLE  = 0;
    localparam int OWN_TLB   = 1;
    localparam int OWN_CACHE = 2;

    logic clk = 1'b0;
    logic i_reset;
    zap_wb_walk_fill_arbiter_if bus ();

    zap_wb_walk_fill_arbiter dut (
        .i_clk   (clk),
        .i_reset (i_reset),
        .bus     (bus.master)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    int          m_owner = OWN_IDLE;
    bit          m_last  = 1'b1;
    logic [73:0] m_bus   = '0;
    bit          m_valid = 1'b0;
    stim_t       cur;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [73:0] bus_for(input int owner, input stim_t s);
        if (owner == OWN_TLB)
            return {s.t_cyc, s.t_stb, s.t_adr, s.t_wen, s.t_sel, s.t_dat, 3'b111};
        if (owner == OWN_CACHE)
            return {s.c_cyc, s.c_stb, s.c_adr, s.c_wen, s.c_sel, s.c_dat, s.c_cti};
        return '0;
    endfunction

    // Drive one cycle's inputs at the falling edge and compare against the model's current state.
    task automatic drive(input stim_t s);
        logic [73:0] dut_bus;
        @(negedge clk);
        cur = s;
        i_reset                = s.rst;
        bus.i_tlb_wb_cyc_nxt   = s.t_cyc;
        bus.i_tlb_wb_stb_nxt   = s.t_stb;
        bus.i_tlb_wb_adr_nxt   = s.t_adr;
        bus.i_tlb_wb_wen_nxt   = s.t_wen;
        bus.i_tlb_wb_sel_nxt   = s.t_sel;
        bus.i_tlb_wb_dat_nxt   = s.t_dat;
        bus.i_cache_wb_cyc_nxt = s.c_cyc;
        bus.i_cache_wb_stb_nxt = s.c_stb;
        bus.i_cache_wb_adr_nxt = s.c_adr;
        bus.i_cache_wb_wen_nxt = s.c_wen;
        bus.i_cache_wb_sel_nxt = s.c_sel;
        bus.i_cache_wb_dat_nxt = s.c_dat;
        bus.i_cache_wb_cti_nxt = s.c_cti;
        bus.i_wb_ack           = s.ack;
        bus.i_wb_err           = s.err;
        bus.i_wb_dat           = s.rdat;
        #1;
        if (m_valid) begin
            dut_bus = {bus.o_wb_cyc, bus.o_wb_stb, bus.o_wb_adr, bus.o_wb_wen,
                       bus.o_wb_sel, bus.o_wb_dat, bus.o_wb_cti};
            check("bus",       128'(dut_bus), 128'(m_bus));
            check("tlb_ack",   128'(bus.o_tlb_wb_ack),   128'(s.ack && m_owner == OWN_TLB));
            check("tlb_err",   128'(bus.o_tlb_wb_err),   128'(s.err && m_owner == OWN_TLB));
            check("cache_ack", 128'(bus.o_cache_wb_ack), 128'(s.ack && m_owner == OWN_CACHE));
            check("cache_err", 128'(bus.o_cache_wb_err), 128'(s.err && m_owner == OWN_CACHE));
            check("rdat",      128'(bus.o_wb_rdat),      128'(s.rdat));
        end
    endtask

    // Advance the reference model across the rising edge.
    task automatic commit();
        int          nxt;
        bit          lst;
        logic [73:0] nb;
        lst = m_last;
        if (cur.rst) begin
            nxt = OWN_IDLE;
            lst = 1'b1;
        end else begin
            case (m_owner)
                OWN_TLB:   nxt = cur.t_cyc ? OWN_TLB : OWN_IDLE;
                OWN_CACHE: nxt = cur.c_cyc ? OWN_CACHE : OWN_IDLE;
                default: begin
                    if (cur.t_cyc && cur.c_cyc) nxt = m_last ? OWN_TLB : OWN_CACHE;
                    else if (cur.t_cyc)         nxt = OWN_TLB;
                    else if (cur.c_cyc)         nxt = OWN_CACHE;
                    else                        nxt = OWN_IDLE;
                    if (nxt != OWN_IDLE) lst = (nxt == OWN_CACHE);
                end
            endcase
        end
        nb = bus_for(nxt, cur);
        @(posedge clk);
        m_owner = nxt;
        m_last  = lst;
        m_bus   = nb;
        if (cur.rst) m_valid = 1'b1;
    endtask

    task automatic apply(input stim_t s);
        drive(s);
        commit();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        stim_t s;
        i_reset = 1'b1;

        // Reset, then a single TLB read.
        s = '0; s.rst = 1'b1;
        apply(s);
        #1;
        check("rst_cyc", 128'(bus.o_wb_cyc), 128'(0));
        check("rst_cti", 128'(bus.o_wb_cti), 128'(0));
        s = '0; s.t_cyc = 1'b1; s.t_stb = 1'b1; s.t_adr = 32'h0000_4000; s.t_sel = 4'hF;
        apply(s);
        #1;
        check("t1_cyc", 128'({bus.o_wb_cyc, bus.o_wb_stb}), 128'(2'b11));
        check("t1_adr", 128'(bus.o_wb_adr), 128'(32'h0000_4000));
        check("t1_cti", 128'(bus.o_wb_cti), 128'(3'b111));
        s.ack = 1'b1; s.rdat = 32'hDEAD_BEEF;
        drive(s);
        check("t1_tack", 128'(bus.o_tlb_wb_ack), 128'(1));
        check("t1_cack", 128'(bus.o_cache_wb_ack), 128'(0));
        check("t1_rdat", 128'(bus.o_wb_rdat), 128'(32'hDEAD_BEEF));
        commit();

        // Simultaneous requests after reset: TLB first, cache after one idle cycle.
        s = '0; s.rst = 1'b1;
        apply(s);
        s = '0;
        s.t_cyc = 1'b1; s.t_stb = 1'b1; s.t_adr = 32'h0000_2000; s.t_sel = 4'hF;
        s.c_cyc = 1'b1; s.c_stb = 1'b1; s.c_adr = 32'h0000_8000; s.c_sel = 4'hF; s.c_cti = 3'b010;
        apply(s);
        #1;
        check("t2_grant_tlb", 128'({bus.o_wb_cyc, bus.o_wb_cti}), 128'({1'b1, 3'b111}));
        for (int i = 0; i < 3; i++) apply(s);
        s.t_cyc = 1'b0; s.t_stb = 1'b0;
        apply(s);
        #1;
        check("t2_gap", 128'(bus.o_wb_cyc), 128'(0));
        apply(s);
        #1;
        check("t2_cache_cyc", 128'(bus.o_wb_cyc), 128'(1));
        check("t2_cache_adr", 128'(bus.o_wb_adr), 128'(32'h0000_8000));

        // Round-robin: cache served last, so TLB wins next, then cache.
        s.c_cyc = 1'b0; s.c_stb = 1'b0;
        apply(s);
        s.t_cyc = 1'b1; s.t_stb = 1'b1; s.c_cyc = 1'b1; s.c_stb = 1'b1;
        apply(s);
        #1;
        check("rr_tlb", 128'({bus.o_wb_cti, bus.o_wb_adr}), 128'({3'b111, 32'h0000_2000}));
        s.t_cyc = 1'b0; s.t_stb = 1'b0; s.c_cyc = 1'b0; s.c_stb = 1'b0;
        apply(s);
        s.t_cyc = 1'b1; s.t_stb = 1'b1; s.c_cyc = 1'b1; s.c_stb = 1'b1;
        apply(s);
        #1;
        check("rr_cache", 128'({bus.o_wb_cti, bus.o_wb_adr}), 128'({3'b010, 32'h0000_8000}));
        s = '0;
        apply(s);

        // No preemption: 4-beat cache burst while TLB requests.
        s = '0; s.c_cyc = 1'b1; s.c_stb = 1'b1; s.c_adr = 32'h100; s.c_sel = 4'hF; s.c_cti = 3'b010;
        s.t_adr = 32'h0000_3000; s.t_sel = 4'hF;
        apply(s);
        for (int i = 0; i < 4; i++) begin
            s.ack = 1'b1;
            s.t_cyc = (i >= 1); s.t_stb = (i >= 1);
            if (i < 3) begin
                s.c_adr = 32'h100 + 32'(4 * (i + 1));
                s.c_cti = (i == 2) ? 3'b111 : 3'b010;
            end else begin
                s.c_cyc = 1'b0; s.c_stb = 1'b0;
            end
            drive(s);
            check("burst_adr",  128'(bus.o_wb_adr), 128'(32'h100 + 32'(4 * i)));
            check("burst_cti",  128'(bus.o_wb_cti), 128'((i == 3) ? 3'b111 : 3'b010));
            check("burst_cack", 128'(bus.o_cache_wb_ack), 128'(1));
            check("burst_tack", 128'(bus.o_tlb_wb_ack), 128'(0));
            commit();
        end
        s.ack = 1'b0;
        drive(s);
        check("burst_gap", 128'(bus.o_wb_cyc), 128'(0));
        commit();
        #1;
        check("burst_tlb_after", 128'({bus.o_wb_cyc, bus.o_wb_cti}), 128'({1'b1, 3'b111}));

        // Error routing during TLB ownership, then a stray ack in IDLE.
        s.err = 1'b1;
        drive(s);
        check("err_tlb",   128'(bus.o_tlb_wb_err), 128'(1));
        check("err_cache", 128'(bus.o_cache_wb_err), 128'(0));
        commit();
        s = '0;
        apply(s);
        s.ack = 1'b1;
        drive(s);
        check("stray_ack", 128'({bus.o_tlb_wb_ack, bus.o_cache_wb_ack}), 128'(0));
        commit();

        // Reset during cache ownership.
        s = '0; s.c_cyc = 1'b1; s.c_stb = 1'b1; s.c_adr = 32'h0000_0200; s.c_cti = 3'b010;
        apply(s);
        apply(s);
        s.t_cyc = 1'b1; s.t_stb = 1'b1; s.t_adr = 32'h0000_5000; s.rst = 1'b1;
        apply(s);
        #1;
        check("rstmid_cyc", 128'(bus.o_wb_cyc), 128'(0));
        s.rst = 1'b0;
        apply(s);
        #1;
        check("rstmid_tlb", 128'({bus.o_wb_cti, bus.o_wb_adr}), 128'({3'b111, 32'h0000_5000}));

        // Randomized traffic; request lines are sticky-ish so ownership periods are realistic.
        s = '0;
        for (int n = 0; n < 3000; n++) begin
            s.rst   = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 3) == 0) s.t_cyc = ~s.t_cyc;
            if ($urandom_range(0, 3) == 0) s.c_cyc = ~s.c_cyc;
            s.t_stb = 1'($urandom);
            s.t_wen = 1'($urandom);
            s.t_adr = $urandom;
            s.t_sel = 4'($urandom);
            s.t_dat = $urandom;
            s.c_stb = 1'($urandom);
            s.c_wen = 1'($urandom);
            s.c_adr = $urandom;
            s.c_sel = 4'($urandom);
            s.c_dat = $urandom;
            s.c_cti = 3'($urandom);
            s.ack   = 1'($urandom);
            s.err   = ($urandom_range(0, 7) == 0);
            s.rdat  = $urandom;
            apply(s);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
